// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : clock_pkg                                                   |
// | Brief  : Shared definitions for the digital-clock set controller:    |
// |          mode encoding, BCD wrap constants, blink mask bit           |
// |          positions and the mode-advance helper.                      |
// | Ports  : none (package)                                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package clock_pkg;

  // Mode encoding is visible on the mode output, so values are fixed.
  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam logic [7:0] c_bcd_00 = 8'h00;
  localparam logic [7:0] c_bcd_59 = 8'h59;
  localparam logic [7:0] c_bcd_23 = 8'h23;

  // Bit positions inside blink = {hour, min, sec}.
  localparam int c_blink_hour = 2;
  localparam int c_blink_min  = 1;
  localparam int c_blink_sec  = 0;

  // RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_RUN:      next_mode = MODE_SET_HOUR;
      MODE_SET_HOUR: next_mode = MODE_SET_MIN;
      MODE_SET_MIN:  next_mode = MODE_SET_SEC;
      default:       next_mode = MODE_RUN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_inc_wrap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bcd_inc_wrap                                                |
// | Brief  : Combinational two-digit BCD +1 that wraps to 00 when the    |
// |          input equals the supplied maximum.                          |
// | Ports  : val     [7:0] in  BCD value to increment                    |
// |          max_val [7:0] in  BCD value at which the result wraps to 00 |
// |          result  [7:0] out incremented / wrapped BCD value           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module bcd_inc_wrap
  import clock_pkg::*;
(
  input  logic [7:0] val,
  input  logic [7:0] max_val,
  output logic [7:0] result
);

  always_comb begin
    result = val;
    if (val == max_val) begin
      result = c_bcd_00;
    end else if (val[3:0] >= 4'd9) begin
      // Low digit rolls over and carries into the tens digit.
      result = {val[7:4] + 4'd1, 4'h0};
    end else begin
      result = {val[7:4], val[3:0] + 4'd1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : clock_set_controller                                        |
// | Brief  : Sequencing controller for the BCD hh:mm:ss counter chain.   |
// |          Counts time on the 1 Hz tick in RUN, and in the set modes   |
// |          loads the selected field with its BCD increment on btn_inc. |
// |          Also produces the display blink mask.                       |
// | Ports  : CP        in   clock (posedge)                              |
// |          CR        in   asynchronous active-low reset                |
// |          tick      in   1 Hz single-cycle enable                     |
// |          btn_mode  in   advance mode pulse                           |
// |          btn_inc   in   increment selected field pulse               |
// |          hh/mm/ss  in   current time, BCD [7:0] each                 |
// |          sec_en/min_en/hour_en  out  stage count enables             |
// |          ld_sec/ld_min/ld_hour  out  stage synchronous load strobes  |
// |          ld_data   out  BCD load value [7:0]                         |
// |          mode      out  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC         |
// |          blink     out  blank mask {hour,min,sec}                    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module clock_set_controller
  import clock_pkg::*;
#(
  parameter logic [7:0] HOUR_MAX = c_bcd_23,
  parameter logic [7:0] MIN_MAX  = c_bcd_59
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       ld_sec,
  output logic       ld_min,
  output logic       ld_hour,
  output logic [7:0] ld_data,
  output logic [1:0] mode,
  output logic [2:0] blink
);

  mode_e      r_state;
  mode_e      w_state_nxt;
  logic       r_phase;
  logic       w_phase_nxt;

  logic       w_sec_en, w_min_en, w_hour_en;
  logic       w_ld_sec, w_ld_min, w_ld_hour;
  logic [7:0] w_ld_data;
  logic [2:0] w_blink;

  logic [7:0] w_field;
  logic [7:0] w_field_max;
  logic [7:0] w_field_inc;

  logic       w_sec_at_max, w_min_at_max, w_hour_at_max;

  assign w_sec_at_max  = (ss == MIN_MAX);
  assign w_min_at_max  = (mm == MIN_MAX);
  assign w_hour_at_max = (hh == HOUR_MAX);

  // Field under edit; the RUN arm is a don't-care since no load uses it.
  always_comb begin
    w_field     = ss;
    w_field_max = MIN_MAX;
    case (r_state)
      MODE_SET_HOUR: begin
        w_field     = hh;
        w_field_max = HOUR_MAX;
      end
      MODE_SET_MIN:  w_field = mm;
      default:       w_field = ss;
    endcase
  end

  bcd_inc_wrap u_inc (
    .val     (w_field),
    .max_val (w_field_max),
    .result  (w_field_inc)
  );

  // State register
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      r_state <= MODE_RUN;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next state and next output values
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase ^ tick;  // phase follows every tick, in any mode
    w_sec_en    = 1'b0;
    w_min_en    = 1'b0;
    w_hour_en   = 1'b0;
    w_ld_sec    = 1'b0;
    w_ld_min    = 1'b0;
    w_ld_hour   = 1'b0;
    w_ld_data   = c_bcd_00;
    w_blink     = 3'b000;

    if (btn_mode) begin
      // Mode change takes priority; a coincident tick or increment is dropped.
      w_state_nxt = next_mode(r_state);
    end else if (r_state == MODE_RUN) begin
      if (tick) begin
        w_sec_en = 1'b1;
        if (w_sec_at_max) begin
          w_ld_sec = 1'b1;
          if (w_min_at_max) begin
            w_ld_min = 1'b1;
            if (w_hour_at_max) w_ld_hour = 1'b1;
            else               w_hour_en = 1'b1;
          end else begin
            w_min_en = 1'b1;
          end
        end
      end
    end else if (btn_inc) begin
      w_ld_data = w_field_inc;
      case (r_state)
        MODE_SET_HOUR: w_ld_hour = 1'b1;
        MODE_SET_MIN:  w_ld_min  = 1'b1;
        default:       w_ld_sec  = 1'b1;
      endcase
    end

    // Mask is computed from the values the registers take next, so a new
    // field picks up the phase on the cycle the mode output changes.
    case (w_state_nxt)
      MODE_SET_HOUR: w_blink[c_blink_hour] = w_phase_nxt;
      MODE_SET_MIN:  w_blink[c_blink_min]  = w_phase_nxt;
      MODE_SET_SEC:  w_blink[c_blink_sec]  = w_phase_nxt;
      default:       w_blink               = 3'b000;
    endcase
  end

  // Output registers
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      sec_en  <= 1'b0;
      min_en  <= 1'b0;
      hour_en <= 1'b0;
      ld_sec  <= 1'b0;
      ld_min  <= 1'b0;
      ld_hour <= 1'b0;
      ld_data <= c_bcd_00;
      blink   <= 3'b000;
    end else begin
      sec_en  <= w_sec_en;
      min_en  <= w_min_en;
      hour_en <= w_hour_en;
      ld_sec  <= w_ld_sec;
      ld_min  <= w_ld_min;
      ld_hour <= w_ld_hour;
      ld_data <= w_ld_data;
      blink   <= w_blink;
    end
  end

  assign mode = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_clock_set_controller                                     |
// | Brief  : Self-checking bench for clock_set_controller. Directed      |
// |          scenarios followed by randomized pulses and BCD times,      |
// |          compared every cycle against a behavioural model that works |
// |          on binary field values.                                     |
// | Ports  : none                                                        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_clock_set_controller;

  logic       CP = 1'b0;
  logic       CR;
  logic       tick, btn_mode, btn_inc;
  logic [7:0] hh, mm, ss;
  logic       sec_en, min_en, hour_en, ld_sec, ld_min, ld_hour;
  logic [7:0] ld_data;
  logic [1:0] mode;
  logic [2:0] blink;

  always #5 CP = ~CP;

  clock_set_controller dut (
    .CP       (CP),
    .CR       (CR),
    .tick     (tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hh       (hh),
    .mm       (mm),
    .ss       (ss),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .hour_en  (hour_en),
    .ld_sec   (ld_sec),
    .ld_min   (ld_min),
    .ld_hour  (ld_hour),
    .ld_data  (ld_data),
    .mode     (mode),
    .blink    (blink)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  int         m_mode  = 0;
  bit         m_phase = 1'b0;
  logic       e_sec_en = 0, e_min_en = 0, e_hour_en = 0;
  logic       e_ld_sec = 0, e_ld_min = 0, e_ld_hour = 0;
  logic [7:0] e_ld_data = 8'h00;
  logic [2:0] e_blink = 3'b000;

  function automatic int b2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  always @(posedge CP or negedge CR) begin
    if (!CR) begin
      m_mode = 0; m_phase = 1'b0;
      e_sec_en = 0; e_min_en = 0; e_hour_en = 0;
      e_ld_sec = 0; e_ld_min = 0; e_ld_hour = 0;
      e_ld_data = 8'h00; e_blink = 3'b000;
    end else begin
      e_sec_en = 0; e_min_en = 0; e_hour_en = 0;
      e_ld_sec = 0; e_ld_min = 0; e_ld_hour = 0;
      e_ld_data = 8'h00;
      if (tick) m_phase = ~m_phase;
      if (btn_mode) begin
        m_mode = (m_mode + 1) % 4;
      end else if (m_mode == 0) begin
        if (tick) begin
          e_sec_en = 1;
          if (b2i(ss) == 59) begin
            e_ld_sec = 1;
            if (b2i(mm) == 59) begin
              e_ld_min = 1;
              if (b2i(hh) == 23) e_ld_hour = 1;
              else               e_hour_en = 1;
            end else begin
              e_min_en = 1;
            end
          end
        end
      end else if (btn_inc) begin
        case (m_mode)
          1: begin e_ld_hour = 1; e_ld_data = i2b((b2i(hh) + 1) % 24); end
          2: begin e_ld_min  = 1; e_ld_data = i2b((b2i(mm) + 1) % 60); end
          default: begin e_ld_sec = 1; e_ld_data = i2b((b2i(ss) + 1) % 60); end
        endcase
      end
      // mode 1 -> bit 2 (hour), 2 -> bit 1 (min), 3 -> bit 0 (sec)
      e_blink = (m_mode == 0) ? 3'b000 : (3'({2'b00, m_phase}) << (3 - m_mode));
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge CP) begin
    if (chk_en) begin
      check("sec_en",  8'(sec_en),  8'(e_sec_en));
      check("min_en",  8'(min_en),  8'(e_min_en));
      check("hour_en", 8'(hour_en), 8'(e_hour_en));
      check("ld_sec",  8'(ld_sec),  8'(e_ld_sec));
      check("ld_min",  8'(ld_min),  8'(e_ld_min));
      check("ld_hour", 8'(ld_hour), 8'(e_ld_hour));
      check("ld_data", ld_data,     e_ld_data);
      check("mode",    8'(mode),    8'(m_mode));
      check("blink",   8'(blink),   8'(e_blink));
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; returns at the next falling edge, when the
  // registered response to these inputs is visible.
  task automatic drive(input logic t, input logic bm, input logic bi,
                       input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    tick = t; btn_mode = bm; btn_inc = bi; hh = h; mm = m; ss = s;
    @(negedge CP);
  endtask

  function automatic logic [7:0] rnd_field(input int maxv);
    if ($urandom_range(0, 2) == 0) return i2b(maxv);
    return i2b(int'($urandom_range(0, maxv)));
  endfunction

  task automatic rnd_inputs();
    tick     = ($urandom_range(0, 3) == 0);
    btn_mode = ($urandom_range(0, 9) == 0);
    btn_inc  = ($urandom_range(0, 3) == 0);
    hh = rnd_field(23); mm = rnd_field(59); ss = rnd_field(59);
  endtask

  initial begin
    CR = 1'b0; tick = 0; btn_mode = 0; btn_inc = 0; hh = 0; mm = 0; ss = 0;
    @(posedge CP);
    @(negedge CP);
    chk_en = 1'b1;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      rnd_inputs();
      @(negedge CP);
      check("rst_mode", 8'(mode), 8'h00);
      check("rst_ld_data", ld_data, 8'h00);
      check("rst_strobes", 8'({sec_en, min_en, hour_en, ld_sec, ld_min, ld_hour, blink}), 8'h00);
    end
    CR = 1'b1;
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    drive(0, 0, 1, 8'h09, 8'h00, 8'h00);
    check("run_inc_ignored", 8'({ld_hour, ld_min, ld_sec}), 8'h00);

    // RUN carry into minutes
    drive(1, 0, 0, 8'h12, 8'h34, 8'h59);
    check("carry_ld_sec", 8'(ld_sec), 8'h01);
    check("carry_ld_data", ld_data, 8'h00);
    check("carry_min_en", 8'(min_en), 8'h01);
    check("carry_hour_en", 8'(hour_en), 8'h00);
    check("carry_sec_en", 8'(sec_en), 8'h01);
    check("model_carry_min_en", 8'(e_min_en), 8'h01);

    // Full rollover 23:59:59
    drive(1, 0, 0, 8'h23, 8'h59, 8'h59);
    check("roll_loads", 8'({ld_hour, ld_min, ld_sec}), 8'h07);
    check("roll_ld_data", ld_data, 8'h00);
    check("roll_enables", 8'({hour_en, min_en}), 8'h00);
    check("model_roll_ld_hour", 8'(e_ld_hour), 8'h01);

    // SET_HOUR
    drive(0, 1, 0, 8'h09, 8'h00, 8'h00);
    check("set_hour_mode", 8'(mode), 8'h01);
    check("set_hour_blink0", 8'(blink), 8'h00);
    drive(0, 0, 1, 8'h09, 8'h00, 8'h00);
    check("inc_09_ld_hour", 8'(ld_hour), 8'h01);
    check("inc_09_data", ld_data, 8'h10);
    check("model_inc_09_data", e_ld_data, 8'h10);
    drive(0, 0, 1, 8'h23, 8'h00, 8'h00);
    check("inc_23_ld_hour", 8'(ld_hour), 8'h01);
    check("inc_23_data", ld_data, 8'h00);
    drive(1, 0, 0, 8'h23, 8'h59, 8'h59);
    check("set_tick_no_en", 8'({sec_en, min_en, hour_en}), 8'h00);
    check("set_hour_blink1", 8'(blink), 8'h04);

    // SET_MIN, then mode+inc together
    drive(0, 1, 0, 8'h00, 8'h30, 8'h00);
    check("set_min_blink", 8'(blink), 8'h02);
    drive(1, 0, 0, 8'h00, 8'h59, 8'h59);
    check("set_min_tick_no_en", 8'({sec_en, min_en, hour_en}), 8'h00);
    check("set_min_blink0", 8'(blink), 8'h00);
    drive(0, 1, 1, 8'h00, 8'h30, 8'h00);
    check("prio_mode", 8'(mode), 8'h03);
    check("prio_no_load", 8'({ld_min, ld_sec}), 8'h00);

    // SET_SEC blink, then mode sequence
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
    check("sec_blink_1", 8'(blink), 8'h01);
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
    check("sec_blink_2", 8'(blink), 8'h00);
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00);
    check("seq_run", 8'(mode), 8'h00);
    check("run_blink", 8'(blink), 8'h00);
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00);
    check("seq_hour", 8'(mode), 8'h01);
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00);
    check("seq_min", 8'(mode), 8'h02);
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00);
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00);
    check("seq_back_run", 8'(mode), 8'h00);

    // btn_mode with tick in RUN: tick dropped
    drive(1, 1, 0, 8'h23, 8'h59, 8'h59);
    check("mode_tick_mode", 8'(mode), 8'h01);
    check("mode_tick_dropped", 8'({sec_en, ld_sec, ld_min, ld_hour}), 8'h00);

    // Reset aborting a pending load
    tick = 0; btn_mode = 0; btn_inc = 1; hh = 8'h05;
    #2 CR = 1'b0;
    @(negedge CP);
    check("abort_ld_hour", 8'(ld_hour), 8'h00);
    check("abort_mode", 8'(mode), 8'h00);
    CR = 1'b1;
    drive(0, 0, 0, 8'h05, 8'h00, 8'h00);
    check("abort_after_release", 8'({ld_hour, ld_min, ld_sec}), 8'h00);

    // Randomized run, with occasional asynchronous reset pulses
    for (int i = 0; i < 4000; i++) begin
      rnd_inputs();
      if ($urandom_range(0, 299) == 0) begin
        #2 CR = 1'b0;
        @(negedge CP);
        CR = 1'b1;
      end else begin
        @(negedge CP);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Sequencing controller for the digital-clock datapath: drives the count-enable and synchronous-load controls of the cascaded BCD seconds/minutes/hours counter stages, which are built from 4-bit presettable counters.
- Runs the time in RUN mode.
- Provides a button-driven set mode that cycles HOUR, MIN and SEC and increments the selected field.
- Sits between the debounced button/1 Hz tick logic and the counter chain; also drives the display blink mask.

Parameters:
- HOUR_MAX, 8'h23, BCD value at which the hour field wraps to 00.
- MIN_MAX, 8'h59, BCD wrap value for the minute and second fields.

Ports:
- CP  input  1  clock; all state changes on posedge.
- CR  input  1  asynchronous active-low reset.
- tick  input  1  single-cycle 1 Hz enable pulse.
- btn_mode  input  1  single-cycle debounced pulse; advances the mode.
- btn_inc  input  1  single-cycle debounced pulse; increments the selected field.
- hh  input  8  current hours, BCD, from the counter chain.
- mm  input  8  current minutes, BCD.
- ss  input  8  current seconds, BCD.
- sec_en  output  1  count enable, seconds stage.
- min_en  output  1  count enable, minutes stage.
- hour_en  output  1  count enable, hours stage.
- ld_sec  output  1  synchronous load strobe, seconds stage.
- ld_min  output  1  synchronous load strobe, minutes stage.
- ld_hour  output  1  synchronous load strobe, hours stage.
- ld_data  output  8  BCD value to load; valid when any ld_* is high.
- mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.
- blink  output  3  per-field blank mask {hour,min,sec}; 1 = blank the field.

Behaviour:
- All outputs are registered. A tick or button pulse in cycle N produces its outputs in cycle N+1, each asserted for exactly one cycle.
- Reset (CR=0, asynchronous): mode=RUN, all *_en=0, all ld_*=0, ld_data=8'h00, blink=3'b000, internal blink phase=0. Reset mid-operation aborts any pending strobe; no load is issued after release.
- FSM: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN, one step per btn_mode pulse.
- RUN, tick=1:
  - sec_en=1.
  - If ss==MIN_MAX: ld_sec=1 with ld_data=00, and minute carry.
  - Minute carry with mm!=MIN_MAX: min_en=1.
  - Minute carry with mm==MIN_MAX: ld_min=1, ld_data=00 (shared 00 value).
  - If ss==MIN_MAX and mm==MIN_MAX: hour carry. If hh==HOUR_MAX then ld_hour=1, else hour_en=1.
  - Loads override enables on the same stage. At most one ld_data value is ever required per cycle, and it is always 00 in RUN.
- SET_x, btn_inc=1:
  - ld_<x>=1 with ld_data = BCD increment of the field.
  - BCD increment: low nibble 9 -> 0 with high nibble +1. At the field's MAX -> 00 (23->00 for hours, 59->00 for min/sec).
  - All *_en=0 in set modes; ticks are ignored, so time is frozen while setting.
- Simultaneous btn_mode and btn_inc in the same cycle: btn_mode wins; the increment is discarded.
- btn_inc in RUN: ignored.
- btn_mode in the same cycle as tick in RUN: mode advances and the tick is dropped.
- Blink:
  - The phase toggles on every tick in every mode.
  - In SET_x, the selected field's blink bit equals the phase; the other bits are 0.
  - In RUN, blink=000.
  - On a mode change, the new field's bit takes the current phase on the next cycle.
- An invalid BCD input (nibble >9) is undefined; it need not be handled.

Decomposition:
- Shared package (clock_pkg): mode encoding constants (MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN, MODE_SET_SEC), the BCD constants 8'h59 and 8'h23, and the blink bit positions.
- One natural sub-module: bcd_inc_wrap, a combinational 8-bit BCD +1 with a max-value wrap input. It is instantiated once, fed by a field mux selected by mode.

Test Plan:
- Reset: hold CR=0 with random inputs -> all outputs 0, mode=0. Release, apply btn_inc -> no ld_* asserted.
- RUN carry: hh=8'h12, mm=8'h34, ss=8'h59, tick -> next cycle ld_sec=1, ld_data=00, min_en=1, hour_en=0, sec_en=1.
- Full rollover: hh=8'h23, mm=8'h59, ss=8'h59, tick -> ld_sec=ld_min=ld_hour=1, ld_data=00, min_en=hour_en=0.
- Set hours: btn_mode once -> mode=1. With hh=8'h09, btn_inc -> ld_hour=1, ld_data=8'h10. With hh=8'h23, btn_inc -> ld_data=8'h00. Ticks during SET_HOUR -> no *_en.
- Priority: in SET_MIN, btn_mode and btn_inc in the same cycle -> mode=3, no ld_min. Three more btn_mode pulses (from mode 3) -> sequence RUN, SET_HOUR, SET_MIN.
- Blink: in SET_SEC, two ticks -> blink goes 001, then 000. Switching to RUN -> blink=000 next cycle.
